mac_dot_with_mem: RTL and testbench

Parametrised multi-word dot-product engine on the shared near-memory bus. On `start` it streams `len` activation words and `len` kernel words from memory. It multiplies the packed lanes pairwise and accumulates all lane products across all words, with an optional bias pre-read from the output location. It writes one accumulated word back and pulses `done`. It is the generalised successor of the single-word 4-lane MAC and adds variable length, lane geometry, signed mode and accumulate-into-output.

---
 rtl/mac_dot_with_mem.sv | 194 +++++++++++++++++++
 tb/tb_mac_dot_with_mem.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_with_mem.sv
// Multi-word packed-lane dot-product engine on the shared near-memory bus.
// Optionally pre-reads a bias, streams A/K word pairs, accumulates lane products, writes one result.
module mac_dot_with_mem #(
    parameter int LANES         = 4,
    parameter int LANE_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATABUS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    len,
    input  logic [ADDR_WIDTH-1:0]    a_addr,
    input  logic [ADDR_WIDTH-1:0]    kernel_addr,
    input  logic [ADDR_WIDTH-1:0]    output_addr,
    input  logic                     signed_mode,
    input  logic                     accumulate,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_sel,
    output logic                     mem_w,
    inout  wire  [ADDR_WIDTH-1:0]    address_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus
);

    localparam int PW = 2 * LANE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_BIAS = 3'd1,
        S_RD_A    = 3'd2,
        S_RD_K    = 3'd3,
        S_MAC     = 3'd4,
        S_WR      = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                   state_r;
    logic [ADDR_WIDTH-1:0]    len_r;
    logic [ADDR_WIDTH-1:0]    a_base_r;
    logic [ADDR_WIDTH-1:0]    k_base_r;
    logic [ADDR_WIDTH-1:0]    out_addr_r;
    logic                     sgn_r;
    logic [ADDR_WIDTH-1:0]    i_r;
    logic [DATABUS_WIDTH-1:0] acc_r;
    logic [DATABUS_WIDTH-1:0] a_word_r;
    logic [DATABUS_WIDTH-1:0] k_word_r;
    logic [ADDR_WIDTH-1:0]    addr_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     mem_sel_r;
    logic                     mem_w_r;
    logic [ADDR_WIDTH-1:0]    next_i_s;
    logic [DATABUS_WIDTH-1:0] mac_sum_s;

    // Sign/zero-extending each lane to 2*LANE_WIDTH makes the truncated product correct in both modes.
    function automatic logic [DATABUS_WIDTH-1:0] lane_dot(
        input logic [DATABUS_WIDTH-1:0] a_w,
        input logic [DATABUS_WIDTH-1:0] k_w,
        input logic                     sgn
    );
        logic [DATABUS_WIDTH-1:0] sum;
        logic [LANE_WIDTH-1:0]    a_l;
        logic [LANE_WIDTH-1:0]    k_l;
        logic [PW-1:0]            a_x;
        logic [PW-1:0]            k_x;
        logic [PW-1:0]            prod;
        sum = '0;
        for (int j = 0; j < LANES; j++) begin
            a_l  = a_w[j*LANE_WIDTH +: LANE_WIDTH];
            k_l  = k_w[j*LANE_WIDTH +: LANE_WIDTH];
            a_x  = {{LANE_WIDTH{sgn & a_l[LANE_WIDTH-1]}}, a_l};
            k_x  = {{LANE_WIDTH{sgn & k_l[LANE_WIDTH-1]}}, k_l};
            prod = a_x * k_x;
            sum  = sum + {{(DATABUS_WIDTH-PW){sgn & prod[PW-1]}}, prod};
        end
        return sum;
    endfunction

    // Lane products of the current word pair and the next word index.
    always_comb begin
        mac_sum_s = lane_dot(a_word_r, k_word_r, sgn_r);
        next_i_s  = i_r + ADDR_WIDTH'(1);
    end

    assign address_bus = mem_sel_r ? addr_r : {ADDR_WIDTH{1'bz}};
    assign data_bus    = mem_w_r   ? acc_r  : {DATABUS_WIDTH{1'bz}};
    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_sel     = mem_sel_r;
    assign mem_w       = mem_w_r;

    // Sequencer: bus controls are set one edge ahead so each bus state sees them registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            len_r      <= '0;
            a_base_r   <= '0;
            k_base_r   <= '0;
            out_addr_r <= '0;
            sgn_r      <= 1'b0;
            i_r        <= '0;
            acc_r      <= '0;
            a_word_r   <= '0;
            k_word_r   <= '0;
            addr_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mem_sel_r  <= 1'b0;
            mem_w_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        len_r      <= len;
                        a_base_r   <= a_addr;
                        k_base_r   <= kernel_addr;
                        out_addr_r <= output_addr;
                        sgn_r      <= signed_mode;
                        i_r        <= '0;
                        acc_r      <= '0;
                        busy_r     <= 1'b1;
                        mem_sel_r  <= 1'b1;
                        if (accumulate) begin
                            state_r <= S_RD_BIAS;
                            addr_r  <= output_addr;
                        end else if (len != '0) begin
                            state_r <= S_RD_A;
                            addr_r  <= a_addr;
                        end else begin
                            state_r <= S_WR;
                            addr_r  <= output_addr;
                            mem_w_r <= 1'b1;
                        end
                    end
                end
                S_RD_BIAS: begin
                    acc_r <= data_bus;
                    if (len_r != '0) begin
                        state_r <= S_RD_A;
                        addr_r  <= a_base_r;
                    end else begin
                        state_r <= S_WR;
                        addr_r  <= out_addr_r;
                        mem_w_r <= 1'b1;
                    end
                end
                S_RD_A: begin
                    a_word_r <= data_bus;
                    addr_r   <= k_base_r + i_r;
                    state_r  <= S_RD_K;
                end
                S_RD_K: begin
                    k_word_r  <= data_bus;
                    mem_sel_r <= 1'b0;
                    state_r   <= S_MAC;
                end
                S_MAC: begin
                    acc_r     <= acc_r + mac_sum_s;
                    i_r       <= next_i_s;
                    mem_sel_r <= 1'b1;
                    if (next_i_s < len_r) begin
                        state_r <= S_RD_A;
                        addr_r  <= a_base_r + next_i_s;
                    end else begin
                        state_r <= S_WR;
                        addr_r  <= out_addr_r;
                        mem_w_r <= 1'b1;
                    end
                end
                S_WR: begin
                    mem_sel_r <= 1'b0;
                    mem_w_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b1;
                    state_r   <= S_DONE;
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r   <= S_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    mem_sel_r <= 1'b0;
                    mem_w_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_with_mem.sv
// Randomised self-checking bench for mac_dot_with_mem: a memory model on the bus and
// a per-cycle expected bus trace built from the job description.
module tb_mac_dot_with_mem;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  a_addr;
    logic [7:0]  kernel_addr;
    logic [7:0]  output_addr;
    logic        signed_mode;
    logic        accumulate;
    logic        busy;
    logic        done;
    logic        mem_sel;
    logic        mem_w;
    wire  [7:0]  address_bus;
    wire  [31:0] data_bus;

    logic [31:0] mem [0:255];
    int          n_pass;
    int          n_total;
    int          wcount;
    int          bcount;

    typedef struct {
        logic        busy;
        logic        done;
        logic        sel;
        logic        w;
        logic [7:0]  addr;
        logic [31:0] data;
    } cyc_t;

    cyc_t exp_q[$];

    mac_dot_with_mem dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .a_addr(a_addr), .kernel_addr(kernel_addr), .output_addr(output_addr),
        .signed_mode(signed_mode), .accumulate(accumulate),
        .busy(busy), .done(done), .mem_sel(mem_sel), .mem_w(mem_w),
        .address_bus(address_bus), .data_bus(data_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read memory.
    assign data_bus = (mem_sel && !mem_w) ? mem[address_bus] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (mem_sel && mem_w) begin
            mem[address_bus] = data_bus;
            wcount = wcount + 1;
        end
    end

    always @(negedge clk) begin
        if (busy) bcount = bcount + 1;
    end

    task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, want);
    endtask

    // Dot product from the arithmetic rules, reading the pre-job memory.
    function automatic logic [31:0] model(input logic [7:0] n, input logic [7:0] a, input logic [7:0] k,
                                          input logic [7:0] o, input logic sgn, input logic accm);
        longint      s;
        logic [31:0] wa;
        logic [31:0] wk;
        logic [7:0]  la;
        logic [7:0]  lk;
        s = accm ? longint'(mem[o]) : 64'sd0;
        for (int i = 0; i < int'(n); i++) begin
            wa = mem[a + 8'(i)];
            wk = mem[k + 8'(i)];
            for (int j = 0; j < 4; j++) begin
                la = wa[j*8 +: 8];
                lk = wk[j*8 +: 8];
                if (sgn) s += longint'($signed(la)) * longint'($signed(lk));
                else     s += longint'(la) * longint'(lk);
            end
        end
        return s[31:0];
    endfunction

    task automatic push(input logic b, input logic d, input logic s, input logic w,
                        input logic [7:0] addr, input logic [31:0] data);
        cyc_t c;
        c.busy = b; c.done = d; c.sel = s; c.w = w; c.addr = addr; c.data = data;
        exp_q.push_back(c);
    endtask

    // Per-cycle comparison against the expected trace (idle expectations when the trace is empty).
    always @(negedge clk) begin
        cyc_t e;
        bit   ok;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (busy == e.busy) && (done == e.done) && (mem_sel == e.sel) && (mem_w == e.w)
                 && (!e.sel || address_bus == e.addr) && (!e.w || data_bus == e.data);
            check(ok, "cycle", {20'd0, busy, done, mem_sel, mem_w, address_bus, data_bus},
                  {20'd0, e.busy, e.done, e.sel, e.w, e.addr, e.data});
        end else begin
            check(!busy && !done && !mem_sel && !mem_w, "idle",
                  {60'd0, busy, done, mem_sel, mem_w}, 64'd0);
        end
    end

    task automatic scramble();
        len         = 8'($urandom);
        a_addr      = 8'($urandom);
        kernel_addr = 8'($urandom);
        output_addr = 8'($urandom);
        signed_mode = 1'($urandom);
        accumulate  = 1'($urandom);
    endtask

    task automatic run_job(input logic [7:0] n, input logic [7:0] a, input logic [7:0] k, input logic [7:0] o,
                           input logic sgn, input logic accm, input bit poke,
                           output logic [31:0] res, output int bcyc);
        int guard;
        res = model(n, a, k, o, sgn, accm);
        @(posedge clk); #1;
        len = n; a_addr = a; kernel_addr = k; output_addr = o;
        signed_mode = sgn; accumulate = accm; start = 1'b1;
        @(posedge clk); #1;
        start  = poke;
        scramble();
        bcount = 0;
        if (accm) push(1'b1, 1'b0, 1'b1, 1'b0, o, 32'd0);
        for (int i = 0; i < int'(n); i++) begin
            push(1'b1, 1'b0, 1'b1, 1'b0, a + 8'(i), 32'd0);
            push(1'b1, 1'b0, 1'b1, 1'b0, k + 8'(i), 32'd0);
            push(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        end
        push(1'b1, 1'b0, 1'b1, 1'b1, o, res);
        push(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        if (poke) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check(exp_q.size() == 0, "job_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check(mem[o] == res, "result", 64'(mem[o]), 64'(res));
        bcyc = bcount;
    endtask

    initial begin
        logic [31:0] res;
        int          bc;
        int          wc0;
        n_pass = 0; n_total = 0; wcount = 0; bcount = 0;
        start = 1'b0; len = 8'd0; a_addr = 8'd0; kernel_addr = 8'd0; output_addr = 8'd0;
        signed_mode = 1'b0; accumulate = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #1 rst_n = 1'b0;
        #2;
        check(!busy && !done && !mem_sel && !mem_w, "reset_state", {60'd0, busy, done, mem_sel, mem_w}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Unsigned single word.
        mem[8'h10] = 32'h0403_0201; mem[8'h20] = 32'h0101_0101;
        run_job(8'd1, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, res, bc);
        check(res == 32'h0000_000A, "single_value", 64'(res), 64'h0A);
        check(bc == 4, "single_busy", 64'(bc), 64'd4);

        // Multi-word.
        for (int i = 0; i < 3; i++) begin
            mem[8'h40 + 8'(i)] = 32'h0101_0101;
            mem[8'h50 + 8'(i)] = 32'h0202_0202;
        end
        run_job(8'd3, 8'h40, 8'h50, 8'h60, 1'b0, 1'b0, 1'b0, res, bc);
        check(res == 32'h0000_0018, "multi_value", 64'(res), 64'h18);
        check(bc == 10, "multi_busy", 64'(bc), 64'd10);

        // Sign mode.
        mem[8'h70] = 32'hFFFF_FFFF; mem[8'h71] = 32'h0202_0202;
        run_job(8'd1, 8'h70, 8'h71, 8'h72, 1'b1, 1'b0, 1'b0, res, bc);
        check(res == 32'hFFFF_FFF8, "signed_value", 64'(res), 64'hFFFF_FFF8);
        run_job(8'd1, 8'h70, 8'h71, 8'h72, 1'b0, 1'b0, 1'b0, res, bc);
        check(res == 32'h0000_07F8, "unsigned_value", 64'(res), 64'h7F8);

        // Accumulate into output.
        mem[8'h30] = 32'd100;
        run_job(8'd1, 8'h10, 8'h20, 8'h30, 1'b0, 1'b1, 1'b0, res, bc);
        check(res == 32'd110, "accum_value", 64'(res), 64'd110);
        check(bc == 5, "accum_busy", 64'(bc), 64'd5);

        // len = 0.
        run_job(8'd0, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, res, bc);
        check(res == 32'd0, "len0_value", 64'(res), 64'd0);
        check(bc == 1, "len0_busy", 64'(bc), 64'd1);

        // Address wrap on A.
        mem[8'hFF] = 32'h0101_0101; mem[8'h00] = 32'h0202_0202;
        mem[8'h90] = 32'h0101_0101; mem[8'h91] = 32'h0101_0101;
        run_job(8'd2, 8'hFF, 8'h90, 8'h92, 1'b0, 1'b0, 1'b0, res, bc);
        check(res == 32'h0000_000C, "wrap_value", 64'(res), 64'h0C);

        // start pulsed while busy.
        wc0 = wcount;
        run_job(8'd3, 8'h40, 8'h50, 8'h61, 1'b0, 1'b0, 1'b1, res, bc);
        check(wcount == wc0 + 1, "poke_writes", 64'(wcount - wc0), 64'd1);

        // Reset during RD_K: no write, bus released at once.
        wc0 = wcount;
        @(posedge clk); #1;
        len = 8'd2; a_addr = 8'h40; kernel_addr = 8'h50; output_addr = 8'hA0;
        signed_mode = 1'b0; accumulate = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push(1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check(!busy && !done && !mem_sel && !mem_w, "reset_midop", {60'd0, busy, done, mem_sel, mem_w}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        check(wcount == wc0, "reset_nowrite", 64'(wcount - wc0), 64'd0);
        run_job(8'd1, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, res, bc);
        check(res == 32'h0000_000A, "after_reset_value", 64'(res), 64'h0A);

        // Randomised jobs.
        for (int t = 0; t < 40; t++) begin
            logic [7:0] n;
            logic       accm;
            n    = 8'($urandom_range(0, 12));
            accm = 1'($urandom);
            run_job(n, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), accm,
                    bit'($urandom_range(0, 3) == 0), res, bc);
            check(bc == (accm ? 1 : 0) + 3 * int'(n) + 1, "rand_busy", 64'(bc),
                  64'((accm ? 1 : 0) + 3 * int'(n) + 1));
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
